// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU issue/writeback stage.
//   alu_op_t  - the ten ALU opcode encodings understood by the registered alu block
//   OPC_*     - RV32I major opcodes handled by the decoder
//   F7_*      - funct7 values distinguishing base and alternate (SUB/SRA) forms
//   b_sel_t   - operand-B source select produced by the decoder
//   dec_t     - decoded instruction bundle passed from alu_decode to alu_issue
package alu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_AND  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_ONE  = 4'd6,
        ALU_ZERO = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_LUI  = 4'd9
    } alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        B_RS2       = 2'd0,   // rs2 as-is
        B_RS2_NEG   = 2'd1,   // two's complement of rs2 (SUB)
        B_RS2_SHAMT = 2'd2,   // rs2[4:0], zero-extended (register shifts)
        B_IMM       = 2'd3    // decoded immediate
    } b_sel_t;

    typedef struct packed {
        alu_op_t             op;
        logic                a_zero;    // operand A forced to zero (LUI)
        b_sel_t              b_sel;
        logic [XLEN-1:0]     imm;
        logic [REG_AW-1:0]   rd;
        logic                uses_rs1;
        logic                uses_rs2;
        logic                illegal;
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32I decoder for OP, OP-IMM and LUI.
// Ports:
//   instr - 32-bit instruction word
//   dec   - decoded bundle: ALU op, operand selects, immediate, rd,
//           source-use flags and illegal flag
// Illegal instructions report no source use so they never stall the stage.
module alu_decode
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output dec_t            dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Opcode/funct decode into ALU controls
    always_comb begin
        dec          = '0;
        dec.op       = ALU_ADD;
        dec.b_sel    = B_RS2;
        dec.rd       = instr[11:7];
        illegal      = 1'b0;

        case (opcode)
            OPC_OP: begin
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ALT) begin
                            dec.b_sel = B_RS2_NEG;
                        end else if (funct7 != F7_BASE) begin
                            illegal = 1'b1;
                        end
                    end
                    3'b001: begin
                        dec.op    = ALU_SLL;
                        dec.b_sel = B_RS2_SHAMT;
                        illegal   = (funct7 != F7_BASE);
                    end
                    3'b100: begin
                        dec.op  = ALU_XOR;
                        illegal = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        dec.b_sel = B_RS2_SHAMT;
                        if (funct7 == F7_BASE) begin
                            dec.op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec.op = ALU_SRA;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    3'b110: begin
                        dec.op  = ALU_OR;
                        illegal = (funct7 != F7_BASE);
                    end
                    3'b111: begin
                        dec.op  = ALU_AND;
                        illegal = (funct7 != F7_BASE);
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.uses_rs1 = 1'b1;
                dec.b_sel    = B_IMM;
                dec.imm      = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    3'b000: dec.op = ALU_ADD;
                    3'b100: dec.op = ALU_XOR;
                    3'b110: dec.op = ALU_OR;
                    3'b111: dec.op = ALU_AND;
                    3'b001: begin
                        dec.op  = ALU_SLL;
                        dec.imm = {27'd0, instr[24:20]};
                        illegal = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        dec.imm = {27'd0, instr[24:20]};
                        if (funct7 == F7_BASE) begin
                            dec.op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec.op = ALU_SRA;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.a_zero = 1'b1;
                dec.b_sel  = B_IMM;
                dec.imm    = {instr[31:12], 12'd0};
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            dec.uses_rs1 = 1'b0;
            dec.uses_rs2 = 1'b0;
        end
        dec.illegal = illegal;
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue and writeback control for the registered alu block.
// Accepts one RV32I OP/OP-IMM/LUI instruction per cycle, drives registered
// ALU operands, tracks the one-cycle ALU latency and presents the returning
// result to the register file. RAW hazards against in-flight results stall
// the input; with ALU_ISSUE_FWD_EN defined, a result returning this cycle is
// forwarded into the operands instead of stalling.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   instr_i/instr_valid_i        - instruction input
//   instr_ready_o                - combinational accept (no hazard)
//   rs1_addr_o/rs2_addr_o        - combinational register-file read indices
//   rs1_data_i/rs2_data_i        - same-cycle register-file read data
//   alu_op_o/alu_a_o/alu_b_o     - registered ALU command
//   alu_result_i                 - ALU registered result
//   wb_valid_o/wb_rd_o/wb_data_o - writeback strobe, index, data
//   illegal_o                    - pulse after accepting an unsupported instruction
// Optional feature macro: ALU_ISSUE_FWD_EN (result forwarding).
module alu_issue
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [XLEN-1:0]     instr_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    output logic [REG_AW-1:0]   rs1_addr_o,
    output logic [REG_AW-1:0]   rs2_addr_o,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    output alu_op_t             alu_op_o,
    output logic [XLEN-1:0]     alu_a_o,
    output logic [XLEN-1:0]     alu_b_o,
    input  logic [XLEN-1:0]     alu_result_i,
    output logic                wb_valid_o,
    output logic [REG_AW-1:0]   wb_rd_o,
    output logic [XLEN-1:0]     wb_data_o,
    output logic                illegal_o
);

    dec_t              dec;
    logic              s1_valid;
    logic [REG_AW-1:0] s1_rd;
    logic              s2_valid;
    logic [REG_AW-1:0] s2_rd;

    logic              rs1_hit_s1;
    logic              rs2_hit_s1;
    logic              rs1_hit_s2;
    logic              rs2_hit_s2;
    logic              stall;
    logic              accept;
    logic              issue;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   a_next;
    logic [XLEN-1:0]   b_next;

    alu_decode u_decode (
        .instr (instr_i),
        .dec   (dec)
    );

    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    // Source matches against results still in flight; x0 never creates a hazard
    assign rs1_hit_s1 = dec.uses_rs1 && s1_valid && (s1_rd != '0) && (s1_rd == rs1_addr_o);
    assign rs2_hit_s1 = dec.uses_rs2 && s1_valid && (s1_rd != '0) && (s1_rd == rs2_addr_o);
    assign rs1_hit_s2 = dec.uses_rs1 && s2_valid && (s2_rd != '0) && (s2_rd == rs1_addr_o);
    assign rs2_hit_s2 = dec.uses_rs2 && s2_valid && (s2_rd != '0) && (s2_rd == rs2_addr_o);

`ifdef ALU_ISSUE_FWD_EN
    // S1 result does not exist yet; S2 result is on alu_result_i and is forwarded
    assign stall   = rs1_hit_s1 || rs2_hit_s1;
    assign rs1_val = rs1_hit_s2 ? alu_result_i : rs1_data_i;
    assign rs2_val = rs2_hit_s2 ? alu_result_i : rs2_data_i;
`else
    // Register file is written at the end of the S2 cycle, so wait it out
    assign stall   = rs1_hit_s1 || rs2_hit_s1 || rs1_hit_s2 || rs2_hit_s2;
    assign rs1_val = rs1_data_i;
    assign rs2_val = rs2_data_i;
`endif

    assign instr_ready_o = !stall;
    assign accept        = instr_valid_i && instr_ready_o;
    assign issue         = accept && !dec.illegal;

    // Operand formation; SUB negation is applied after forwarding
    always_comb begin
        a_next = dec.a_zero ? '0 : rs1_val;
        b_next = rs2_val;
        case (dec.b_sel)
            B_RS2:       b_next = rs2_val;
            B_RS2_NEG:   b_next = ~rs2_val + 32'd1;
            B_RS2_SHAMT: b_next = {27'd0, rs2_val[4:0]};
            B_IMM:       b_next = dec.imm;
            default:     b_next = rs2_val;
        endcase
    end

    // Pipeline and ALU command registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_op_o  <= ALU_ADD;
            alu_a_o   <= '0;
            alu_b_o   <= '0;
            s1_valid  <= 1'b0;
            s1_rd     <= '0;
            s2_valid  <= 1'b0;
            s2_rd     <= '0;
            illegal_o <= 1'b0;
        end else begin
            s1_valid  <= issue;
            s1_rd     <= dec.rd;
            s2_valid  <= s1_valid;
            s2_rd     <= s1_rd;
            illegal_o <= accept && dec.illegal;
            if (issue) begin
                alu_op_o <= dec.op;
                alu_a_o  <= a_next;
                alu_b_o  <= b_next;
            end
        end
    end

    // Writeback straight from the S2 registers; rd=x0 results are dropped here
    assign wb_valid_o = s2_valid && (s2_rd != '0);
    assign wb_rd_o    = s2_rd;
    assign wb_data_o  = alu_result_i;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: bench for alu_issue. Provides a register file and a registered
// ALU around the DUT and checks it against an instruction-level reference
// (architectural register values and per-register readiness times).
module tb_alu_issue;

`ifdef ALU_ISSUE_FWD_EN
    localparam int RAW_LAT = 2;
`else
    localparam int RAW_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instr_i       (instr),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .rs1_addr_o    (rs1_addr),
        .rs2_addr_o    (rs2_addr),
        .rs1_data_i    (rs1_data),
        .rs2_data_i    (rs2_data),
        .alu_op_o      (alu_op),
        .alu_a_o       (alu_a),
        .alu_b_o       (alu_b),
        .alu_result_i  (alu_result),
        .wb_valid_o    (wb_valid),
        .wb_rd_o       (wb_rd),
        .wb_data_o     (wb_data),
        .illegal_o     (illegal)
    );

    // Environment: register file written by the DUT writeback
    logic [31:0] rf [32];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (wb_valid && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end
    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    // Environment: registered ALU
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a & b;
            4'd2:    return a << b[4:0];
            4'd3:    return a >> b[4:0];
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return 32'd1;
            4'd7:    return 32'd0;
            4'd8:    return 32'($signed(a) >>> b[4:0]);
            4'd9:    return b;
            default: return 32'd0;
        endcase
    endfunction
    always @(posedge clk) alu_result <= alu_fn(alu_op, alu_a, alu_b);

    // Reference state
    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    logic [31:0] gold [32];
    int          ready_at [32];
    wb_exp_t     wbq [$];
    int          cyc = 0;
    int          alu_due = -1;
    int          ill_due = -1;
    logic [3:0]  exp_op;
    logic [31:0] exp_a, exp_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            gold[i]     = 32'h0;
            ready_at[i] = 0;
        end
        wbq.delete();
        alu_due = -1;
        ill_due = -1;
        cyc     = 0;
    endtask

    // Instruction semantics straight from the ISA definition
    function automatic void ref_exec(input logic [31:0] ins, output bit legal, output logic [3:0] op,
                                     output logic [31:0] a, output logic [31:0] b, output logic [31:0] res,
                                     output bit u1, output bit u2);
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] v1, v2, immi;
        logic [4:0]  sh;
        opc  = ins[6:0];
        f7   = ins[31:25];
        f3   = ins[14:12];
        v1   = gold[ins[19:15]];
        v2   = gold[ins[24:20]];
        immi = {{20{ins[31]}}, ins[31:20]};
        legal = 1'b1; u1 = 1'b0; u2 = 1'b0;
        op = 4'd0; a = 32'h0; b = 32'h0; res = 32'h0;
        if (opc == 7'b0110011) begin
            u1 = 1'b1; u2 = 1'b1; a = v1; b = v2; sh = v2[4:0];
            case ({f7, f3})
                {7'h00, 3'd0}: res = v1 + v2;
                {7'h20, 3'd0}: begin b = 32'd0 - v2; res = v1 - v2; end
                {7'h00, 3'd1}: begin op = 4'd2; b = {27'd0, sh}; res = v1 << sh; end
                {7'h00, 3'd4}: begin op = 4'd5; res = v1 ^ v2; end
                {7'h00, 3'd5}: begin op = 4'd3; b = {27'd0, sh}; res = v1 >> sh; end
                {7'h20, 3'd5}: begin op = 4'd8; b = {27'd0, sh}; res = 32'($signed(v1) >>> sh); end
                {7'h00, 3'd6}: begin op = 4'd4; res = v1 | v2; end
                {7'h00, 3'd7}: begin op = 4'd1; res = v1 & v2; end
                default:       legal = 1'b0;
            endcase
        end else if (opc == 7'b0010011) begin
            u1 = 1'b1; a = v1; b = immi; sh = ins[24:20];
            case (f3)
                3'd0: res = v1 + immi;
                3'd4: begin op = 4'd5; res = v1 ^ immi; end
                3'd6: begin op = 4'd4; res = v1 | immi; end
                3'd7: begin op = 4'd1; res = v1 & immi; end
                3'd1: begin
                    op = 4'd2; b = {27'd0, sh}; res = v1 << sh;
                    if (f7 != 7'h00) legal = 1'b0;
                end
                3'd5: begin
                    b = {27'd0, sh};
                    if (f7 == 7'h00) begin op = 4'd3; res = v1 >> sh; end
                    else if (f7 == 7'h20) begin op = 4'd8; res = 32'($signed(v1) >>> sh); end
                    else legal = 1'b0;
                end
                default: legal = 1'b0;
            endcase
        end else if (opc == 7'b0110111) begin
            b = {ins[31:12], 12'd0};
            res = b;
        end else begin
            legal = 1'b0;
        end
        if (!legal) begin u1 = 1'b0; u2 = 1'b0; end
    endfunction

    // Checks of registered outputs, just after each rising edge
    task automatic cycle_check();
        wb_exp_t e;
        chk("illegal", 32'(illegal), 32'(ill_due == cyc));
        if (alu_due == cyc) begin
            chk("alu_op", 32'(alu_op), 32'(exp_op));
            chk("alu_a", alu_a, exp_a);
            chk("alu_b", alu_b, exp_b);
        end
        if (wbq.size() > 0 && wbq[0].due == cyc) begin
            e = wbq.pop_front();
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_rd", 32'(wb_rd), 32'(e.rd));
            chk("wb_data", wb_data, e.data);
        end else begin
            chk("wb_valid_idle", 32'(wb_valid), 32'd0);
        end
    endtask

    // One cycle: present instruction, check ready, update model, advance clock
    task automatic drive(input logic [31:0] ins, input bit vld, output bit acc);
        bit          legal, u1, u2, exp_rdy;
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic [4:0]  rd;
        ref_exec(ins, legal, op, a, b, res, u1, u2);
        exp_rdy = !((u1 && ready_at[ins[19:15]] > cyc) || (u2 && ready_at[ins[24:20]] > cyc));
        instr       = ins;
        instr_valid = vld;
        #1;
        chk("ready", 32'(instr_ready), 32'(exp_rdy));
        acc = vld && exp_rdy;
        if (acc) begin
            if (!legal) begin
                ill_due = cyc + 1;
            end else begin
                rd      = ins[11:7];
                alu_due = cyc + 1;
                exp_op  = op;
                exp_a   = a;
                exp_b   = b;
                if (rd != 5'd0) begin
                    wbq.push_back('{due: cyc + 2, rd: rd, data: res});
                    gold[rd]     = res;
                    ready_at[rd] = cyc + RAW_LAT;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        cycle_check();
    endtask

    task automatic issue(input logic [31:0] ins, output int stalls);
        bit acc;
        acc    = 1'b0;
        stalls = 0;
        while (!acc && stalls < 8) begin
            drive(ins, 1'b1, acc);
            if (!acc) stalls++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) drive(32'h00000013, 1'b0, acc);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        int          kind;
        rd   = 5'($urandom_range(0, 3));
        r1   = 5'($urandom_range(0, 3));
        r2   = 5'($urandom_range(0, 3));
        f3   = 3'($urandom_range(0, 7));
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
        f7   = 7'h00;
        imm  = 12'($urandom);
        kind = int'($urandom_range(0, 9));
        if (kind < 4) begin
            if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
            return {f7, r2, r1, f3, rd, 7'b0110011};
        end else if (kind < 7) begin
            if (f3 == 3'd1) imm[11:5] = 7'h00;
            else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            return {imm, r1, f3, rd, 7'b0010011};
        end else if (kind == 7) begin
            return {20'($urandom), rd, 7'b0110111};
        end
        case ($urandom_range(0, 4))
            0:       return {7'h00, r2, r1, 3'd2, rd, 7'b0110011};
            1:       return {7'h01, r2, r1, 3'd0, rd, 7'b0110011};
            2:       return {imm, r1, 3'd3, rd, 7'b0010011};
            3:       return {7'h20, r2, r1, 3'd1, rd, 7'b0010011};
            default: return {imm, r1, 3'd2, rd, 7'b0000011};
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        bit          acc;
        bit          pend;
        logic [31:0] pins;

        model_clear();
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        reset_n = 1'b1;

        // ADDI x1,x0,5
        issue(32'h00500093, st);
        chk("addi_stalls", 32'(st), 32'd0);
        chk("addi_op", 32'(alu_op), 32'd0);
        chk("addi_a", alu_a, 32'd0);
        chk("addi_b", alu_b, 32'd5);
        idle(1);
        chk("addi_wb_valid", 32'(wb_valid), 32'd1);
        chk("addi_wb_rd", 32'(wb_rd), 32'd1);
        chk("addi_wb_data", wb_data, 32'd5);
        idle(2);

        // SUB x3,x1,x2 with x1=10, x2=3
        issue(32'h00300113, st);
        issue(32'h00a00093, st);
        issue(32'h402081B3, st);
        chk("sub_op", 32'(alu_op), 32'd0);
        chk("sub_b", alu_b, 32'hFFFFFFFD);
        idle(1);
        chk("sub_wb_rd", 32'(wb_rd), 32'd3);
        chk("sub_wb_data", wb_data, 32'd7);
        idle(3);

        // Dependent back-to-back pair
        issue(32'h00500093, st);
        issue(32'h00108113, st);
        chk("raw_bubbles", 32'(st), 32'(RAW_LAT - 1));
        chk("raw_a", alu_a, 32'd5);
        idle(1);
        chk("raw_wb_rd", 32'(wb_rd), 32'd2);
        chk("raw_wb_data", wb_data, 32'd6);
        idle(2);

        // LUI x5,0x12345
        issue(32'h123452B7, st);
        chk("lui_op", 32'(alu_op), 32'd0);
        chk("lui_a", alu_a, 32'd0);
        chk("lui_b", alu_b, 32'h12345000);
        idle(1);
        chk("lui_wb_rd", 32'(wb_rd), 32'd5);
        idle(2);

        // SLT x1,x2,x3 is illegal, then a normal instruction
        issue(32'h003120B3, st);
        chk("slt_illegal", 32'(illegal), 32'd1);
        issue(32'h00900213, st);
        chk("after_slt_stalls", 32'(st), 32'd0);
        chk("after_slt_illegal", 32'(illegal), 32'd0);
        idle(3);

        // Reset while ADDI x1,x0,7 is in flight
        issue(32'h00700093, st);
        #1 reset_n = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_b", alu_b, 32'd0);
        chk("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("mid_rst_illegal", 32'(illegal), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        end
        model_clear();
        reset_n = 1'b1;
        drive(32'h00108093, 1'b0, acc);
        idle(3);

        // Randomised traffic on x0..x3 for dense hazards
        pend = 1'b0;
        pins = 32'h0;
        for (int n = 0; n < 600; n++) begin
            if (!pend) begin
                pins = rand_instr();
                pend = 1'b1;
            end
            drive(pins, $urandom_range(0, 4) != 0, acc);
            if (acc) pend = 1'b0;
        end
        idle(4);
        chk("drain", 32'(wbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
